traffic_light_controller: RTL and testbench

//  Consumes the 1 Hz Slow_Clock from the clock divider as a seconds time base and sequences a two-road

---
 rtl/tlc_pkg.sv | 64 ++++++
 rtl/sync_edge_detect.sv | 37 +++
 rtl/traffic_light_controller.sv | 140 ++++++++++++++
 tb/tb_traffic_light_controller.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// ---------------------------------------------------------------------------
// tlc_pkg
//   Shared definitions for the traffic light controller: FSM state codes,
//   lamp codes and the state -> lamp decode used by the controller.
// ---------------------------------------------------------------------------
package tlc_pkg;

  // 3-bit state register; code 3'd7 is unused and recovers to ALL_RED_2.
  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_1   = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALL_RED_2   = 3'd5,
    PED_WALK    = 3'd6
  } tlc_state_t;

  // Lamp codes, {R,Y,G}
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  typedef struct packed {
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk;
  } lamps_t;

  // Lamp pattern for a state. Anything not explicitly a road-go state shows
  // all red, so an illegal code can never light two roads.
  function automatic lamps_t decode_lamps(input tlc_state_t st);
    lamps_t l;
    l.main_light = RED;
    l.side_light = RED;
    l.walk       = 1'b0;
    case (st)
      MAIN_GREEN:  l.main_light = GRN;
      MAIN_YELLOW: l.main_light = YEL;
      SIDE_GREEN:  l.side_light = GRN;
      SIDE_YELLOW: l.side_light = YEL;
      PED_WALK:    l.walk       = 1'b1;
      default:     ;
    endcase
    return l;
  endfunction

  // Successor state; ped selects the walk phase after the second clearance.
  function automatic tlc_state_t next_state(input tlc_state_t st, input logic ped);
    tlc_state_t n;
    case (st)
      MAIN_GREEN:  n = MAIN_YELLOW;
      MAIN_YELLOW: n = ALL_RED_1;
      ALL_RED_1:   n = SIDE_GREEN;
      SIDE_GREEN:  n = SIDE_YELLOW;
      SIDE_YELLOW: n = ALL_RED_2;
      ALL_RED_2:   n = ped ? PED_WALK : MAIN_GREEN;
      PED_WALK:    n = MAIN_GREEN;
      default:     n = ALL_RED_2;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// ---------------------------------------------------------------------------
// sync_edge_detect
//   Two-flop synchroniser plus one delay flop for an asynchronous level.
//   rise_pulse is high for exactly one Clk cycle per rising edge of async_in,
//   in the cycle after the second synchroniser flop captures the new level.
// Ports
//   Clk        in  system clock
//   Reset      in  asynchronous, active-high reset (all flops to 0)
//   async_in   in  asynchronous level input
//   rise_pulse out one-cycle pulse on a synchronised rising edge
// ---------------------------------------------------------------------------
module sync_edge_detect (
  input  logic Clk,
  input  logic Reset,
  input  logic async_in,
  output logic rise_pulse
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise_pulse = s2 & ~s3;

endmodule

// File: rtl/traffic_light_controller.sv
// ---------------------------------------------------------------------------
// traffic_light_controller
//   Two-road intersection sequencer with a pedestrian walk phase. The 1 Hz
//   Slow_Clock is treated as data: it is synchronised and its rising edge is
//   the seconds tick that advances the per-state countdown.
// Parameters
//   GREEN_SEC, YELLOW_SEC, ALL_RED_SEC, WALK_SEC : state durations in ticks
//   TW                                          : width of Sec_Left
// Ports
//   Clk         in   system clock
//   Reset       in   asynchronous, active-high reset
//   Slow_Clock  in   1 Hz square wave (asynchronous data)
//   Ped_Req     in   raw pedestrian button (asynchronous)
//   Main_Light  out  {R,Y,G} main road, one-hot
//   Side_Light  out  {R,Y,G} side road, one-hot
//   Walk        out  pedestrian walk lamp
//   Ped_Pending out  request latched, walk not yet started
//   Sec_Left    out  ticks remaining in current state
// ---------------------------------------------------------------------------
module traffic_light_controller
  import tlc_pkg::*;
#(
  parameter int GREEN_SEC   = 8,
  parameter int YELLOW_SEC  = 2,
  parameter int ALL_RED_SEC = 1,
  parameter int WALK_SEC    = 5,
  parameter int TW          = 4
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Slow_Clock,
  input  logic          Ped_Req,
  output logic [2:0]    Main_Light,
  output logic [2:0]    Side_Light,
  output logic          Walk,
  output logic          Ped_Pending,
  output logic [TW-1:0] Sec_Left
);

  localparam int MAX_SEC = (2 ** TW) - 1;

  // Zero or oversize durations would break the countdown; refuse to elaborate.
  if (GREEN_SEC < 1 || GREEN_SEC > MAX_SEC) begin : g_bad_green
    $error("GREEN_SEC must be in 1..2**TW-1");
  end
  if (YELLOW_SEC < 1 || YELLOW_SEC > MAX_SEC) begin : g_bad_yellow
    $error("YELLOW_SEC must be in 1..2**TW-1");
  end
  if (ALL_RED_SEC < 1 || ALL_RED_SEC > MAX_SEC) begin : g_bad_all_red
    $error("ALL_RED_SEC must be in 1..2**TW-1");
  end
  if (WALK_SEC < 1 || WALK_SEC > MAX_SEC) begin : g_bad_walk
    $error("WALK_SEC must be in 1..2**TW-1");
  end

  function automatic logic [TW-1:0] duration(input tlc_state_t st);
    logic [TW-1:0] d;
    case (st)
      MAIN_GREEN, SIDE_GREEN:   d = TW'(GREEN_SEC);
      MAIN_YELLOW, SIDE_YELLOW: d = TW'(YELLOW_SEC);
      PED_WALK:                 d = TW'(WALK_SEC);
      default:                  d = TW'(ALL_RED_SEC);
    endcase
    return d;
  endfunction

  logic          sec_tick;
  logic          ped_rise;
  tlc_state_t    state;
  tlc_state_t    state_nxt;
  logic [TW-1:0] sec_left;
  logic          ped_pending;
  logic          ped_pending_nxt;
  lamps_t        lamps;
  logic          state_legal;
  logic          advance;
  logic          enter_walk;

  sync_edge_detect u_slow_sync (
    .Clk        (Clk),
    .Reset      (Reset),
    .async_in   (Slow_Clock),
    .rise_pulse (sec_tick)
  );

  sync_edge_detect u_ped_sync (
    .Clk        (Clk),
    .Reset      (Reset),
    .async_in   (Ped_Req),
    .rise_pulse (ped_rise)
  );

  assign state_legal = (state <= PED_WALK);
  // "<= 1" rather than "== 1" so a corrupted zero count advances instead of wrapping.
  assign advance     = state_legal && sec_tick && (sec_left <= TW'(1));
  assign state_nxt   = next_state(state, ped_pending);
  assign enter_walk  = advance && (state == ALL_RED_2) && ped_pending;

  // Clearing on walk entry wins over a same-cycle press; presses during the
  // walk itself are dropped so they do not queue a second walk.
  always_comb begin
    ped_pending_nxt = ped_pending;
    if (enter_walk) begin
      ped_pending_nxt = 1'b0;
    end else if (ped_rise && (state != PED_WALK)) begin
      ped_pending_nxt = 1'b1;
    end
  end

  // Lamps are registered alongside the state so they always equal the
  // decode of the state register, with no extra cycle of lag.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= ALL_RED_2;
      sec_left    <= TW'(ALL_RED_SEC);
      lamps       <= decode_lamps(ALL_RED_2);
      ped_pending <= 1'b0;
    end else begin
      ped_pending <= ped_pending_nxt;
      if (!state_legal) begin
        state    <= ALL_RED_2;
        sec_left <= TW'(ALL_RED_SEC);
        lamps    <= decode_lamps(ALL_RED_2);
      end else if (advance) begin
        state    <= state_nxt;
        sec_left <= duration(state_nxt);
        lamps    <= decode_lamps(state_nxt);
      end else if (sec_tick) begin
        sec_left <= sec_left - TW'(1);
      end
    end
  end

  assign Main_Light  = lamps.main_light;
  assign Side_Light  = lamps.side_light;
  assign Walk        = lamps.walk;
  assign Ped_Pending = ped_pending;
  assign Sec_Left    = sec_left;

endmodule

// File: tb/tb_traffic_light_controller.sv
module tb_traffic_light_controller;

  localparam int TW = 4;
  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  typedef logic [6+1+TW-1:0] tup_t;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          Slow_Clock = 1'b0;
  logic          Ped_Req = 1'b0;
  logic [2:0]    Main_Light;
  logic [2:0]    Side_Light;
  logic          Walk;
  logic          Ped_Pending;
  logic [TW-1:0] Sec_Left;

  int   checks = 0;
  int   failures = 0;
  tup_t exp_q[$];
  bit   mon_en = 1'b0;
  tup_t prev_t;

  traffic_light_controller #(
    .GREEN_SEC   (8),
    .YELLOW_SEC  (2),
    .ALL_RED_SEC (1),
    .WALK_SEC    (5),
    .TW          (TW)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Slow_Clock  (Slow_Clock),
    .Ped_Req     (Ped_Req),
    .Main_Light  (Main_Light),
    .Side_Light  (Side_Light),
    .Walk        (Walk),
    .Ped_Pending (Ped_Pending),
    .Sec_Left    (Sec_Left)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic tup_t tup(input logic [2:0] m, input logic [2:0] s,
                               input logic w, input int sec);
    return {m, s, w, TW'(sec)};
  endfunction

  function automatic tup_t cur_t();
    return {Main_Light, Side_Light, Walk, Sec_Left};
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: every change of the visible outputs must match the next
  // expected tuple queued by the stimulus.
  always @(negedge Clk) begin
    tup_t c;
    tup_t e;
    if (mon_en) begin
      c = cur_t();
      if (c !== prev_t) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL mon_unexpected actual=%h required=none", c);
        end else begin
          e = exp_q.pop_front();
          if (c !== e) begin
            failures++;
            $display("FAIL mon_output actual=%h required=%h", c, e);
          end
        end
      end
      prev_t = c;
    end
  end

  // Safety invariants, every cycle.
  always @(negedge Clk) begin
    checks++;
    if (!$onehot(Main_Light) || !$onehot(Side_Light) ||
        (Main_Light != R && Side_Light != R) ||
        (Walk && (Main_Light != R || Side_Light != R)) ||
        Sec_Left == '0) begin
      failures++;
      $display("FAIL safety actual=%b_%b_%b_%0d required=safe",
               Main_Light, Side_Light, Walk, Sec_Left);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic run_ticks(input int n);
    repeat (n) begin
      Slow_Clock = 1'b1;
      step(20);
      Slow_Clock = 1'b0;
      step(20);
    end
  endtask

  task automatic push_range(input logic [2:0] m, input logic [2:0] s,
                            input logic w, input int from);
    for (int k = from; k >= 1; k--) exp_q.push_back(tup(m, s, w, k));
  endtask

  // MAIN_YELLOW through ALL_RED_2 with default durations.
  task automatic push_rest();
    push_range(Y, R, 1'b0, 2);
    push_range(R, R, 1'b0, 1);
    push_range(G == 3'b001 ? R : R, G, 1'b0, 8);
    push_range(R, Y, 1'b0, 2);
    push_range(R, R, 1'b0, 1);
  endtask

  task automatic press();
    Ped_Req = 1'b1;
    step(1);
    Ped_Req = 1'b0;
    step(4);
  endtask

  task automatic check_q_empty(input string name);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int n;

    // Reset state
    step(3);
    check("rst_main", Main_Light, R);
    check("rst_side", Side_Light, R);
    check("rst_walk", Walk, 0);
    check("rst_sec", Sec_Left, 1);
    check("rst_pend", Ped_Pending, 0);
    Reset = 1'b0;
    step(1);
    prev_t = cur_t();
    mon_en = 1'b1;

    // Two full periods without pedestrians: 1,8,2,1,8,2,1
    push_range(G, R, 1'b0, 8); push_rest();
    push_range(G, R, 1'b0, 8); push_rest();
    run_ticks(44);
    check_q_empty("seq_period");

    // Tick latency and a long-held Slow_Clock
    exp_q.push_back(tup(G, R, 1'b0, 8));
    Slow_Clock = 1'b1;
    step(2);
    check("tick_early_sec", Sec_Left, 1);
    check("tick_early_main", Main_Light, R);
    step(1);
    check("tick_edge_sec", Sec_Left, 8);
    check("tick_edge_main", Main_Light, G);
    step(197);
    check("tick_hold_sec", Sec_Left, 8);
    Slow_Clock = 1'b0;
    step(20);
    check_q_empty("tick_once");

    // Single pedestrian pulse during MAIN_GREEN
    Ped_Req = 1'b1;
    step(1);
    Ped_Req = 1'b0;
    n = 1;
    while (!Ped_Pending && n < 3) begin
      step(1);
      n++;
    end
    check("ped_pend_set", Ped_Pending, 1);
    push_range(G, R, 1'b0, 7); push_rest();
    push_range(R, R, 1'b1, 5);
    exp_q.push_back(tup(G, R, 1'b0, 8));
    run_ticks(21);
    check("ped_pend_hold", Ped_Pending, 1);
    run_ticks(1);
    check("walk_entry_pend", Ped_Pending, 0);
    check("walk_entry_walk", Walk, 1);
    check("walk_entry_main", Main_Light, R);
    check("walk_entry_side", Side_Light, R);
    check("walk_entry_sec", Sec_Left, 5);
    run_ticks(5);
    check("walk_exit_main", Main_Light, G);
    check("walk_exit_pend", Ped_Pending, 0);
    check_q_empty("ped_cycle");

    // Multiple presses give one walk; a press during the walk is dropped
    repeat (4) press();
    check("multi_pend", Ped_Pending, 1);
    push_range(G, R, 1'b0, 7); push_rest();
    push_range(R, R, 1'b1, 5);
    exp_q.push_back(tup(G, R, 1'b0, 8));
    run_ticks(22);
    check("multi_walk", Walk, 1);
    press();
    step(2);
    check("walk_press_ignored", Ped_Pending, 0);
    run_ticks(5);
    push_range(G, R, 1'b0, 7); push_rest();
    exp_q.push_back(tup(G, R, 1'b0, 8));
    run_ticks(22);
    check_q_empty("no_extra_walk");
    check("no_extra_pend", Ped_Pending, 0);

    // Asynchronous reset in the middle of SIDE_GREEN
    push_range(G, R, 1'b0, 7);
    push_range(Y, R, 1'b0, 2);
    push_range(R, R, 1'b0, 1);
    exp_q.push_back(tup(R, G, 1'b0, 8));
    exp_q.push_back(tup(R, G, 1'b0, 7));
    run_ticks(12);
    check("pre_rst_side", Side_Light, G);
    press();
    check("pre_rst_pend", Ped_Pending, 1);
    exp_q.push_back(tup(R, R, 1'b0, 1));
    Reset = 1'b1;
    #1;
    check("mid_rst_main", Main_Light, R);
    check("mid_rst_side", Side_Light, R);
    check("mid_rst_walk", Walk, 0);
    check("mid_rst_sec", Sec_Left, 1);
    check("mid_rst_pend", Ped_Pending, 0);
    step(3);
    Reset = 1'b0;
    exp_q.push_back(tup(G, R, 1'b0, 8));
    run_ticks(1);
    check("post_rst_main", Main_Light, G);
    check("post_rst_sec", Sec_Left, 8);
    check_q_empty("reset_seq");

    // Random pedestrian / reset traffic at a fast tick rate (10k ticks)
    mon_en = 1'b0;
    for (int cyc = 0; cyc < 40000; cyc++) begin
      Slow_Clock = ((cyc % 4) < 2);
      Ped_Req    = ($urandom_range(0, 15) == 0);
      Reset      = ($urandom_range(0, 2999) == 0);
      step(1);
    end
    Reset = 1'b0;
    Slow_Clock = 1'b0;
    Ped_Req = 1'b0;
    step(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
